// File: rtl/bcd_multi_counter_if.sv
// rtl/bcd_multi_counter_if.sv - control and display bundle for bcd_multi_counter
//
// Ports (slave = counter side):
//   i_clear     clear digits, prescalers and scan index
//   i_load      load i_load_val (BCD, digit k at [4k+3:4k])
//   i_up        count direction, 1 = up
//   i_hold      drop count ticks while high
//   o_bcd       registered count
//   o_wrap      one-cycle wrap pulse
//   o_seg       static segments, digit k at [7k+6:7k]
//   o_scan_seg  segments of the scanned digit
//   o_scan_sel  one-hot scanned digit select
interface bcd_multi_counter_if #(
  parameter int DIGITS = 4
);
  logic                  i_clear;
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_load_val;
  logic                  i_up;
  logic                  i_hold;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_wrap;
  logic [7*DIGITS-1:0]   o_seg;
  logic [6:0]            o_scan_seg;
  logic [DIGITS-1:0]     o_scan_sel;

  modport master (
    output i_clear, i_load, i_load_val, i_up, i_hold,
    input  o_bcd, o_wrap, o_seg, o_scan_seg, o_scan_sel
  );

  modport slave (
    input  i_clear, i_load, i_load_val, i_up, i_hold,
    output o_bcd, o_wrap, o_seg, o_scan_seg, o_scan_sel
  );
endinterface

// File: rtl/bcd_multi_counter.sv
// rtl/bcd_multi_counter.sv - N-digit BCD counter with prescalers and 7-segment drive
//
// Ports:
//   i_clk  system clock
//   rst_n  asynchronous active-low reset
//   bus    bcd_multi_counter_if.slave (controls in, count and segment drive out)
module bcd_multi_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 5_000_000,
  parameter int SCAN_DIV = 5000,
  parameter int LZB      = 0
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  bcd_multi_counter_if.slave    bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic [3:0]        digit_q [DIGITS];
  logic [3:0]        digit_d [DIGITS];
  logic [3:0]        step_val [DIGITS];
  logic              step_carry;
  logic              wrap_q, wrap_d;
  logic [6:0]        seg_q [DIGITS];
  logic [6:0]        seg_d [DIGITS];
  logic              zero_above;
  logic [6:0]        scan_seg_q, scan_seg_d;
  logic [DIGITS-1:0] scan_sel_q, scan_sel_d;
  logic              tick, scan_tick, eff_tick;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign scan_tick = (scan_cnt_q == SCAN_LAST);
  assign eff_tick  = tick & ~bus.i_hold;

  // Ripple one step through the digits; step_carry left set means every
  // digit rolled over, which is exactly the wrap condition.
  always_comb begin
    step_carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      step_val[k] = digit_q[k];
      if (step_carry) begin
        if (bus.i_up) begin
          if (digit_q[k] >= 4'd9) begin
            step_val[k] = 4'd0;
          end else begin
            step_val[k] = digit_q[k] + 4'd1;
            step_carry  = 1'b0;
          end
        end else begin
          if (digit_q[k] == 4'd0) begin
            step_val[k] = 4'd9;
          end else begin
            step_val[k] = digit_q[k] - 4'd1;
            step_carry  = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_tick) begin
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
    wrap_d = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      digit_d[k] = digit_q[k];
    end
    if (bus.i_clear) begin
      tick_cnt_d = '0;
      scan_cnt_d = '0;
      scan_idx_d = '0;
      for (int k = 0; k < DIGITS; k++) begin
        digit_d[k] = 4'd0;
      end
    end else if (bus.i_load) begin
      for (int k = 0; k < DIGITS; k++) begin
        digit_d[k] = (bus.i_load_val[4*k +: 4] > 4'd9) ? 4'd0 : bus.i_load_val[4*k +: 4];
      end
    end else if (eff_tick) begin
      for (int k = 0; k < DIGITS; k++) begin
        digit_d[k] = step_val[k];
      end
      wrap_d = step_carry;
    end
  end

  // Segment patterns come from the registered count, so the display lags
  // o_bcd by one clock. Blanking scans from the top digit down.
  always_comb begin
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (digit_q[k] == 4'd0);
      seg_d[k]   = ((LZB != 0) && (k != 0) && zero_above) ? 7'h00 : seg7(digit_q[k]);
    end
    scan_seg_d = seg_d[scan_idx_q];
    scan_sel_d = '0;
    scan_sel_d[scan_idx_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      wrap_q     <= 1'b0;
      scan_seg_q <= 7'h3F;
      scan_sel_q <= DIGITS'(1);
      for (int k = 0; k < DIGITS; k++) begin
        digit_q[k] <= 4'd0;
        seg_q[k]   <= ((LZB == 0) || (k == 0)) ? 7'h3F : 7'h00;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      wrap_q     <= wrap_d;
      scan_seg_q <= scan_seg_d;
      scan_sel_q <= scan_sel_d;
      for (int k = 0; k < DIGITS; k++) begin
        digit_q[k] <= digit_d[k];
        seg_q[k]   <= seg_d[k];
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_out
    assign bus.o_bcd[4*k +: 4] = digit_q[k];
    assign bus.o_seg[7*k +: 7] = seg_q[k];
  end

  assign bus.o_wrap     = wrap_q;
  assign bus.o_scan_seg = scan_seg_q;
  assign bus.o_scan_sel = scan_sel_q;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// tb/tb_bcd_multi_counter.sv - self-checking bench for bcd_multi_counter
module tb_bcd_multi_counter;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 3;
  localparam int MODV     = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bcd_multi_counter_if #(.DIGITS(DIGITS)) bus_a ();
  bcd_multi_counter_if #(.DIGITS(DIGITS)) bus_b ();

  assign bus_b.i_clear    = bus_a.i_clear;
  assign bus_b.i_load     = bus_a.i_load;
  assign bus_b.i_load_val = bus_a.i_load_val;
  assign bus_b.i_up       = bus_a.i_up;
  assign bus_b.i_hold     = bus_a.i_hold;

  bcd_multi_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .LZB(0)) dut_a (
    .i_clk (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  bcd_multi_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .LZB(1)) dut_b (
    .i_clk (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input int v, input int k, input int lzb);
    if (lzb != 0 && k > 0 && v < pow10(k)) return 7'h00;
    return pat((v / pow10(k)) % 10);
  endfunction

  function automatic logic [27:0] exp_seg(input int v, input int lzb);
    logic [27:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[7*k +: 7] = digit_seg(v, k, lzb);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (lv[4*k +: 4] <= 4'd9) v = v + int'(lv[4*k +: 4]) * pow10(k);
    end
    return v;
  endfunction

  // Reference model: integer count modulo 10^DIGITS, a cycle counter since
  // reset/clear for both prescalers, and one-cycle-delayed copies for display.
  int m_val, m_cyc, m_scans, m_val_d1, m_idx_d1;
  bit m_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val <= 0; m_cyc <= 0; m_scans <= 0; m_wrap <= 1'b0;
      m_val_d1 <= 0; m_idx_d1 <= 0;
    end else begin
      m_val_d1 <= m_val;
      m_idx_d1 <= m_scans % DIGITS;
      if (bus_a.i_clear) begin
        m_val <= 0; m_cyc <= 0; m_scans <= 0; m_wrap <= 1'b0;
      end else begin
        m_cyc <= m_cyc + 1;
        if (m_cyc % SCAN_DIV == SCAN_DIV - 1) m_scans <= m_scans + 1;
        if (bus_a.i_load) begin
          m_val  <= from_load(bus_a.i_load_val);
          m_wrap <= 1'b0;
        end else if ((m_cyc % TICK_DIV == TICK_DIV - 1) && !bus_a.i_hold) begin
          if (bus_a.i_up) begin
            m_val  <= (m_val + 1) % MODV;
            m_wrap <= (m_val == MODV - 1);
          end else begin
            m_val  <= (m_val + MODV - 1) % MODV;
            m_wrap <= (m_val == 0);
          end
        end else begin
          m_wrap <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_bcd_a",  32'(bus_a.o_bcd),      32'(to_bcd(m_val)));
      check("model_bcd_b",  32'(bus_b.o_bcd),      32'(to_bcd(m_val)));
      check("model_wrap_a", 32'(bus_a.o_wrap),     32'(m_wrap));
      check("model_wrap_b", 32'(bus_b.o_wrap),     32'(m_wrap));
      check("model_seg_a",  32'(bus_a.o_seg),      32'(exp_seg(m_val_d1, 0)));
      check("model_seg_b",  32'(bus_b.o_seg),      32'(exp_seg(m_val_d1, 1)));
      check("model_sel_a",  32'(bus_a.o_scan_sel), 32'(1) << m_idx_d1);
      check("model_sel_b",  32'(bus_b.o_scan_sel), 32'(1) << m_idx_d1);
      check("model_sseg_a", 32'(bus_a.o_scan_seg), 32'(digit_seg(m_val_d1, m_idx_d1, 0)));
      check("model_sseg_b", 32'(bus_b.o_scan_seg), 32'(digit_seg(m_val_d1, m_idx_d1, 1)));
    end
  end

  typedef struct {
    logic [15:0] load_val;
    logic        up;
    logic [15:0] exp_load;
    logic [15:0] exp_next;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[8];

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg_b;
  } scan_t;

  scan_t scan_tab[13];
  int    dec_bcd[12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
  int    dec_seg[12] = '{'h3F, 'h3F, 'h3F, 'h3F, 'h06, 'h06, 'h06, 'h06, 'h5B, 'h5B, 'h5B, 'h5B};

  task automatic clear_sync();
    @(negedge clk); bus_a.i_clear = 1'b1;
    @(negedge clk); bus_a.i_clear = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bcd"},   32'(bus_a.o_bcd),      32'h0);
    check({tag, "_wrap"},  32'(bus_a.o_wrap),     32'h0);
    check({tag, "_seg_a"}, 32'(bus_a.o_seg),      32'h07EFDFBF);
    check({tag, "_seg_b"}, 32'(bus_b.o_seg),      32'h0000003F);
    check({tag, "_sel"},   32'(bus_a.o_scan_sel), 32'h1);
    check({tag, "_sseg"},  32'(bus_b.o_scan_seg), 32'h3F);
  endtask

  initial begin
    vecs[0] = '{16'h9999, 1'b1, 16'h9999, 16'h0000, 1'b1};
    vecs[1] = '{16'h0999, 1'b1, 16'h0999, 16'h1000, 1'b0};
    vecs[2] = '{16'h1000, 1'b0, 16'h1000, 16'h0999, 1'b0};
    vecs[3] = '{16'h0000, 1'b0, 16'h0000, 16'h9999, 1'b1};
    vecs[4] = '{16'h12F4, 1'b1, 16'h1204, 16'h1205, 1'b0};
    vecs[5] = '{16'hABCD, 1'b0, 16'h0000, 16'h9999, 1'b1};
    vecs[6] = '{16'h0040, 1'b0, 16'h0040, 16'h0039, 1'b0};
    vecs[7] = '{16'h9990, 1'b1, 16'h9990, 16'h9991, 1'b0};
    scan_tab = '{'{4'h1, 7'h3F}, '{4'h1, 7'h3F}, '{4'h1, 7'h3F},
                 '{4'h2, 7'h66}, '{4'h2, 7'h66}, '{4'h2, 7'h66},
                 '{4'h4, 7'h00}, '{4'h4, 7'h00}, '{4'h4, 7'h00},
                 '{4'h8, 7'h00}, '{4'h8, 7'h00}, '{4'h8, 7'h00},
                 '{4'h1, 7'h3F}};

    bus_a.i_clear = 1'b0; bus_a.i_load = 1'b0; bus_a.i_load_val = '0;
    bus_a.i_up = 1'b1; bus_a.i_hold = 1'b0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("decode_bcd",  32'(bus_a.o_bcd),      32'(dec_bcd[i]));
      check("decode_seg0", 32'(bus_a.o_seg[6:0]), 32'(dec_seg[i]));
    end

    for (int i = 0; i < 8; i++) begin
      clear_sync();
      bus_a.i_load = 1'b1; bus_a.i_load_val = vecs[i].load_val; bus_a.i_up = vecs[i].up;
      @(negedge clk); bus_a.i_load = 1'b0;
      check("vec_load", 32'(bus_a.o_bcd), 32'(vecs[i].exp_load));
      repeat (3) @(negedge clk);
      check("vec_next", 32'(bus_a.o_bcd), 32'(vecs[i].exp_next));
      check("vec_wrap", 32'(bus_a.o_wrap), 32'(vecs[i].exp_wrap));
      @(negedge clk);
      check("vec_wrap_end", 32'(bus_a.o_wrap), 32'h0);
    end

    bus_a.i_up = 1'b1;
    clear_sync();
    repeat (3) @(negedge clk);
    bus_a.i_load = 1'b1; bus_a.i_load_val = 16'h1234;
    @(negedge clk); bus_a.i_load = 1'b0;
    check("load_on_tick", 32'(bus_a.o_bcd), 32'h1234);
    repeat (3) @(negedge clk);
    check("load_tick_lost", 32'(bus_a.o_bcd), 32'h1234);
    @(negedge clk);
    check("after_load_tick", 32'(bus_a.o_bcd), 32'h1235);

    @(negedge clk); bus_a.i_clear = 1'b1; bus_a.i_load = 1'b1; bus_a.i_load_val = 16'h1234;
    @(negedge clk); bus_a.i_clear = 1'b0; bus_a.i_load = 1'b0;
    check("clear_beats_load", 32'(bus_a.o_bcd), 32'h0);

    clear_sync();
    bus_a.i_load = 1'b1; bus_a.i_load_val = 16'h0500; bus_a.i_hold = 1'b1;
    @(negedge clk); bus_a.i_load = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_drop", 32'(bus_a.o_bcd), 32'h0500);
    bus_a.i_hold = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_release", 32'(bus_a.o_bcd), 32'h0501);

    clear_sync();
    bus_a.i_load = 1'b1; bus_a.i_load_val = 16'h0040; bus_a.i_hold = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus_a.i_load = 1'b0;
      check("scan_sel",   32'(bus_b.o_scan_sel), 32'(scan_tab[i].sel));
      check("scan_seg_b", 32'(bus_b.o_scan_seg), 32'(scan_tab[i].seg_b));
      if (i == 1) begin
        check("blank_seg_b", 32'(bus_b.o_seg), 32'h0000333F);
        check("plain_seg_a", 32'(bus_a.o_seg), 32'h07EFF33F);
      end
    end
    bus_a.i_hold = 1'b0;

    clear_sync();
    bus_a.i_load = 1'b1; bus_a.i_load_val = 16'h0057;
    @(negedge clk); bus_a.i_load = 1'b0;
    check("pre_reset_bcd", 32'(bus_a.o_bcd), 32'h0057);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk); rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      begin
        int r;
        r = $urandom_range(0, 99);
        bus_a.i_clear = (r < 2);
        bus_a.i_load  = (r >= 2 && r < 9);
        bus_a.i_hold  = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 29) == 0) bus_a.i_up = ~bus_a.i_up;
        case ($urandom_range(0, 3))
          0: bus_a.i_load_val = 16'h9999;
          1: bus_a.i_load_val = 16'h0000;
          2: bus_a.i_load_val = 16'($urandom);
          default: bus_a.i_load_val = to_bcd(int'($urandom_range(0, MODV - 1)));
        endcase
      end
    end
    @(negedge clk);
    bus_a.i_clear = 1'b0; bus_a.i_load = 1'b0; bus_a.i_hold = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_multi_counter.md
# bcd_multi_counter

Parametrised N-digit BCD counter with built-in enable prescalers, up/down/load/clear control, wrap detection and 7-segment drive for both static (one segment group per digit) and multiplexed (one shared segment bus plus digit select) displays. It is the next-generation replacement for the fixed single-digit 1 Hz BCD counter and its separate enable generators in the display top level. Segment drive is generated internally, so the top level only routes pins.

## Interface

- DIGITS, 4: number of BCD digits, 1..8; digit 0 is least significant.
- TICK_DIV, 5_000_000: count-tick period in clocks, ≥2.
- SCAN_DIV, 5000: multiplex scan period in clocks, ≥2.
- LZB, 0: 1 enables leading-zero blanking.

- i_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous clear of digits and both prescalers.
- i_load  in  1  synchronous load of i_load_val.
- i_load_val  in  4*DIGITS  BCD load value, digit k at [4k+3:4k].
- i_up  in  1  1 = count up, 0 = count down.
- i_hold  in  1  1 = suppress count ticks (prescalers keep running).
- o_bcd  out  4*DIGITS  current count, registered.
- o_wrap  out  1  one-cycle pulse on 99..9→0 (up) or 0→99..9 (down).
- o_seg  out  7*DIGITS  static segments, digit k at [7k+6:7k], bit 0 = A … bit 6 = G, active-high.
- o_scan_seg  out  7  segments of the currently scanned digit.
- o_scan_sel  out  DIGITS  one-hot digit select, bit k = digit k.

## Operation

- Tick prescaler: counter 0..TICK_DIV-1, internal tick high for one cycle when count = TICK_DIV-1, then wraps to 0. Scan prescaler: identical with SCAN_DIV.
- Digit update priority per clock: i_clear > i_load > (tick & ~i_hold) > hold value.
- i_clear: all digits → 0, both prescalers → 0, o_wrap → 0, scan index → 0.
- i_load: digit k ← i_load_val digit k; any digit value >9 is loaded as 0. Load does not touch the prescalers and never raises o_wrap.
- Count up: digit 0 increments; a digit at 9 becomes 0 and carries to the next digit. Count down: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
- Wrap: when all digits are 9 (up) or all digits are 0 (down) on an effective tick, the count wraps and o_wrap = 1 for exactly the cycle in which the new count is visible on o_bcd.
- Segment encode, 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex, G..A). Encoded values >9 produce 00.
- LZB=1: digit k>0 is blanked (00) when it and every higher digit are 0. Digit 0 is never blanked. This applies to both o_seg and o_scan_seg.
- Scan: the scan index advances on each scan tick and wraps DIGITS-1 → 0. o_scan_sel = 1<<index. o_scan_seg is the (blanking-applied) segment pattern of that digit.

## Timing

- Reset (rst_n low, asynchronous): o_bcd = 0, o_wrap = 0, prescalers = 0, scan index = 0, o_scan_sel = 1, o_scan_seg = 3F. o_seg holds 3F in every digit when LZB=0; when LZB=1, digit 0 holds 3F and all other digits hold 00.
- Tick prescaler: from rst_n release, the first tick is high on cycle TICK_DIV-1 (0-based). o_bcd changes on the following edge.
- o_bcd / o_wrap latency: 1 clock after the control (tick, load or clear) is sampled.
- o_seg, o_scan_seg, o_scan_sel: registered, 1 clock after o_bcd or scan index change (2 clocks from the control).
- Simultaneous load and tick: load wins and the tick is lost.
- Simultaneous clear with anything: clear wins.
- i_hold during a tick: the tick is dropped, not deferred.
- i_up may change on any cycle and is sampled only on the tick cycle.
- rst_n asserted mid-count: immediate return to reset values; no wrap pulse is produced.

## Test plan

- Reset/decode (DIGITS=4, TICK_DIV=4, LZB=0): release reset, observe 12 clocks -> o_bcd increments 0000→0001→0002 every 4 clocks; o_seg digit 0 follows 3F→06→5B one clock behind o_bcd.
- Up wrap: load 9999, i_up=1 -> next tick gives o_bcd = 0000 with o_wrap high for exactly 1 cycle; carry chain 0999→1000 verified separately.
- Down wrap/borrow: load 1000, i_up=0 -> next tick gives 0999; load 0000 -> next tick gives 9999 with an o_wrap pulse.
- Priority: assert load (0x1234) on the tick cycle -> o_bcd = 1234, no increment. Assert clear with load -> 0000. Illegal load 0x12F4 -> 1204. Hold across a tick -> value unchanged.
- Blanking/scan (LZB=1, SCAN_DIV=3): o_bcd = 0040 -> o_seg = {00,00,66,3F} (digit 3..0); o_scan_sel cycles 1,2,4,8,1 every 3 clocks with matching o_scan_seg.
- Async reset mid-run: drop rst_n between edges at count 0057 -> outputs reach reset values immediately, without waiting for a clock edge.
